// File: rtl/aes_pkg.sv
// Shared AES constants and types used across the decryption datapath.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;

  // 128-bit state, bits [127:120] = s[0][0], column-major byte order.
  typedef logic [AES_STATE_W-1:0] state_t;

  // InvMixColumns is skipped for the initial (0) and final (nr) AddRoundKey
  // of the inverse cipher; every round strictly between them applies it.
  function automatic logic round_has_mix(input int round, input int nr);
    return (round >= 1) && (round <= nr - 1);
  endfunction

endpackage

// File: rtl/inv_add_round_key_stage_if.sv
// Bus bundle for the inverse AddRoundKey stage: key load port, input
// state handshake and output state handshake.
//
// Handshake rule for both in_* and out_*: a transfer happens at a rising
// clk edge where valid and ready are both 1; the producer holds valid and
// payload stable until that edge, and ready never depends on valid.
interface inv_add_round_key_stage_if #(parameter int RW = 4);
  import aes_pkg::*;

  logic          key_we;
  logic [RW-1:0] key_addr;
  state_t        key_data;

  logic          in_valid;
  logic          in_ready;
  state_t        in_data;
  logic [RW-1:0] in_round;

  logic          out_valid;
  logic          out_ready;
  state_t        out_data;
  logic [RW-1:0] out_round;
  logic          out_mix_en;

  logic          key_miss;
  logic          key_miss_clr;

  // Upstream / test side.
  modport master (
    output key_we, key_addr, key_data,
    output in_valid, in_data, in_round,
    output out_ready, key_miss_clr,
    input  in_ready, out_valid, out_data, out_round, out_mix_en, key_miss
  );

  // Stage side.
  modport slave (
    input  key_we, key_addr, key_data,
    input  in_valid, in_data, in_round,
    input  out_ready, key_miss_clr,
    output in_ready, out_valid, out_data, out_round, out_mix_en, key_miss
  );

endinterface

// File: rtl/aes_skid_fifo2.sv
// Generic 2-entry valid/ready buffer. The output is always the head
// register, so out_* come straight from flops and hold while stalled.
// in_ready depends only on the fill level (and reset), never on out_ready.
module aes_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_ready_o  = !rst && (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Next fill level and entry contents; head is always the oldest entry.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push only happens below full, so count is 1 here: replace head.
        head_d = in_data_i;
      end
      default: ;
    endcase
  end

  // Fill level and entry registers; reset flushes and zeroes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of AES decryption. Holds NR+1 loadable round
// keys, XORs each accepted state with the key chosen by its round index and
// buffers the result for the downstream InvMixColumns stage.
module inv_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int RW = 4          // must satisfy 2**RW > NR; match the bus RW
) (
  input logic                        clk,
  input logic                        rst,
  inv_add_round_key_stage_if.slave   bus
);

  localparam int PW = AES_STATE_W + RW + 1;

  state_t        key_q [NR+1];
  logic [NR:0]   loaded_q, loaded_d;
  logic          key_miss_q, key_miss_d;

  state_t        sel_key;
  logic          key_hit;
  logic          mix;
  logic          accept;
  logic [PW-1:0] push_data;
  logic [PW-1:0] pop_data;

  // Key lookup by round index; indices above NR never match, so they miss.
  // Reads see the registered key, so a same-cycle write is not forwarded.
  always_comb begin
    sel_key = '0;
    key_hit = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      if (bus.in_round == RW'(i)) begin
        sel_key = key_q[i];
        key_hit = loaded_q[i];
      end
    end
    mix       = key_hit && round_has_mix(int'(bus.in_round), NR);
    push_data = {bus.in_data ^ sel_key, bus.in_round, mix};
    if (!key_hit) push_data = {bus.in_data, bus.in_round, 1'b0};
    accept    = bus.in_valid && bus.in_ready;
  end

  // Key storage; out-of-range write addresses match no entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NR; i++) begin
      if (bus.key_we && bus.key_addr == RW'(i)) key_q[i] <= bus.key_data;
    end
  end

  // Loaded bitmap update and sticky miss flag; a new miss beats the clear.
  always_comb begin
    loaded_d = loaded_q;
    for (int i = 0; i <= NR; i++) begin
      if (bus.key_we && bus.key_addr == RW'(i)) loaded_d[i] = 1'b1;
    end
    key_miss_d = key_miss_q;
    if (bus.key_miss_clr)   key_miss_d = 1'b0;
    if (accept && !key_hit) key_miss_d = 1'b1;
  end

  // Loaded bitmap and miss flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q   <= '0;
      key_miss_q <= 1'b0;
    end else begin
      loaded_q   <= loaded_d;
      key_miss_q <= key_miss_d;
    end
  end

  aes_skid_fifo2 #(.W(PW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (push_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (pop_data)
  );

  assign bus.out_data   = pop_data[PW-1 -: AES_STATE_W];
  assign bus.out_round  = pop_data[RW:1];
  assign bus.out_mix_en = pop_data[0];
  assign bus.key_miss   = key_miss_q;

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Bench for the inverse AddRoundKey stage: directed known-answer cases plus
// randomized traffic, with a queue-based scoreboard and an output monitor.
module tb_inv_add_round_key_stage;
  import aes_pkg::*;

  localparam int NR = AES128_NR;
  localparam int RW = 4;
  localparam int W  = AES_STATE_W + RW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_add_round_key_stage_if #(.RW(RW)) bus ();

  inv_add_round_key_stage #(.NR(NR), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  state_t       mdl_key [16];
  bit           mdl_loaded [16];
  bit           mdl_miss;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [W-1:0] model_out(input state_t d, input int r);
    logic m;
    if (r <= NR && mdl_loaded[r]) begin
      m = (r >= 1) && (r <= NR - 1);
      return {d ^ mdl_key[r], RW'(r), m};
    end
    return {d, RW'(r), 1'b0};
  endfunction

  function automatic void model_write(input int a, input state_t k);
    if (a <= NR) begin
      mdl_key[a]    = k;
      mdl_loaded[a] = 1'b1;
    end
  endfunction

  function automatic state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int a, input state_t k);
    bus.in_valid = 1'b0;
    bus.key_we   = 1'b1;
    bus.key_addr = RW'(a);
    bus.key_data = k;
    @(posedge clk);
    model_write(a, k);
    #1;
    bus.key_we = 1'b0;
  endtask

  task automatic clear_miss();
    bus.in_valid     = 1'b0;
    bus.key_miss_clr = 1'b1;
    @(posedge clk);
    mdl_miss = 1'b0;
    #1;
    bus.key_miss_clr = 1'b0;
    check("key_miss_clr", 128'(bus.key_miss), 128'(mdl_miss));
  endtask

  // Presents one state and waits for it to be accepted; leaves in_valid high
  // so back-to-back calls stream one state per cycle.
  task automatic drive_state(input state_t d, input int r);
    int waited;
    bit miss;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_round = RW'(r);
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      if (bus.key_miss_clr) mdl_miss = 1'b0;
      #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    miss = !(r <= NR && mdl_loaded[r]);
    exp_q.push_back(model_out(d, r));
    @(posedge clk);
    if (bus.key_we) model_write(int'(bus.key_addr), bus.key_data);
    if (bus.key_miss_clr) mdl_miss = 1'b0;
    if (miss) mdl_miss = 1'b1;
    #1;
    bus.key_we = 1'b0;
    check("key_miss", 128'(bus.key_miss), 128'(mdl_miss));
  endtask

  task automatic apply_reset(input int cycles);
    bus.in_valid     = 1'b0;
    bus.key_we       = 1'b0;
    bus.key_miss_clr = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_in_ready",   128'(bus.in_ready),   128'(0));
    check("rst_out_valid",  128'(bus.out_valid),  128'(0));
    check("rst_out_data",   bus.out_data,         128'(0));
    check("rst_out_round",  128'(bus.out_round),  128'(0));
    check("rst_out_mix_en", 128'(bus.out_mix_en), 128'(0));
    check("rst_key_miss",   128'(bus.key_miss),   128'(0));
    exp_q.delete();
    for (int i = 0; i < 16; i++) mdl_loaded[i] = 1'b0;
    mdl_miss = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data",   bus.out_data,         mon_exp[W-1 -: AES_STATE_W]);
        check("out_round",  128'(bus.out_round),  128'(mon_exp[RW:1]));
        check("out_mix_en", 128'(bus.out_mix_en), 128'(mon_exp[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  state_t sa, sb, sc, ka, kb, hold_exp;
  logic [W-1:0] head_exp;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mdl_key[i]    = '0;
      mdl_loaded[i] = 1'b0;
    end
    mdl_miss         = 1'b0;
    rst              = 1'b1;
    bus.key_we       = 1'b0;
    bus.key_addr     = '0;
    bus.key_data     = '0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_round     = '0;
    bus.out_ready    = 1'b1;
    bus.key_miss_clr = 1'b0;

    apply_reset(2);

    // Known answer: final-round key.
    write_key(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    drive_state(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
    check("ka10_valid",  128'(bus.out_valid),  128'(1));
    check("ka10_data",   bus.out_data,         128'h7ad5fda789ef4e272bca100b3d9ff59f);
    check("ka10_round",  128'(bus.out_round),  128'(10));
    check("ka10_mix_en", 128'(bus.out_mix_en), 128'(0));

    // Known answer: round 0, then a middle round with mix enabled.
    write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    drive_state(128'h00102030405060708090a0b0c0d0e0f0, 0);
    check("ka0_data",   bus.out_data,         128'h00112233445566778899aabbccddeeff);
    check("ka0_mix_en", 128'(bus.out_mix_en), 128'(0));
    write_key(5, rand_state());
    drive_state(rand_state(), 5);
    check("r5_mix_en", 128'(bus.out_mix_en), 128'(1));

    // Same-cycle write and read of key 2: old key used, new key next time.
    ka = rand_state();
    kb = rand_state();
    sa = rand_state();
    write_key(2, ka);
    bus.key_we   = 1'b1;
    bus.key_addr = RW'(2);
    bus.key_data = kb;
    drive_state(sa, 2);
    check("rbw_old_key", bus.out_data, sa ^ ka);
    drive_state(sa, 2);
    check("rbw_new_key", bus.out_data, sa ^ kb);

    // Randomized traffic with all keys loaded and random backpressure.
    for (int i = 0; i <= NR; i++) write_key(i, rand_state());
    for (int n = 0; n < 40; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive_state(rand_state(), $urandom_range(0, 15));
    end
    bus.out_ready = 1'b1;
    idle(3);

    // Backpressure: two accepted, third held off, head stable.
    bus.out_ready = 1'b0;
    sa = rand_state();
    sb = rand_state();
    sc = rand_state();
    head_exp = model_out(sa, 4);
    hold_exp = head_exp[W-1 -: AES_STATE_W];
    drive_state(sa, 4);
    drive_state(sb, 7);
    bus.in_valid = 1'b1;
    bus.in_data  = sc;
    bus.in_round = RW'(1);
    check("bp_full_in_ready", 128'(bus.in_ready), 128'(0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data",     bus.out_data,        hold_exp);
      check("bp_hold_in_ready", 128'(bus.in_ready),  128'(0));
      check("bp_hold_valid",    128'(bus.out_valid), 128'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", 128'(bus.in_ready), 128'(1));
    drive_state(sc, 1);
    idle(3);

    // Reset with two entries buffered.
    bus.out_ready = 1'b0;
    drive_state(rand_state(), 3);
    drive_state(rand_state(), 6);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    apply_reset(1);
    bus.out_ready = 1'b1;
    sa = rand_state();
    drive_state(sa, 0);
    check("post_rst_miss_data", bus.out_data, sa);

    // Misses: unloaded key, out-of-range round, ignored write, clear races.
    clear_miss();
    sa = rand_state();
    drive_state(sa, 3);
    check("miss3_data", bus.out_data, sa);
    clear_miss();
    sa = rand_state();
    drive_state(sa, 11);
    check("miss11_data",   bus.out_data,         sa);
    check("miss11_round",  128'(bus.out_round),  128'(11));
    check("miss11_mix_en", 128'(bus.out_mix_en), 128'(0));
    clear_miss();
    write_key(12, rand_state());
    drive_state(rand_state(), 12);
    clear_miss();
    bus.key_miss_clr = 1'b1;
    drive_state(rand_state(), 3);
    bus.key_miss_clr = 1'b0;
    check("miss_beats_clr", 128'(bus.key_miss), 128'(1));
    clear_miss();

    idle(5);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
